// File: rtl/irled_pkg.sv
// Shared types and sizing for the IR LED driver sequencer.
package irled_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_BIAS,
    ST_ON,
    ST_COOL,
    ST_FAULT
  } state_e;

  typedef logic owner_t;
  localparam owner_t OWNER_CAM = 1'b0;
  localparam owner_t OWNER_BC  = 1'b1;

  localparam int ON_CNT_W     = 20;
  localparam int SETTLE_CNT_W = 16;
  localparam int COOL_CNT_W   = 16;
  localparam int PWM_PH_W     = 8;

  // Bias is up (and the current code applied) in both BIAS and ON.
  function automatic logic bias_active(input state_e s);
    return (s == ST_BIAS) || (s == ST_ON);
  endfunction

endpackage

// File: rtl/irled_pwm.sv
// PWM generator: 8-bit phase counter compared against the latched duty.
module irled_pwm
  import irled_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic                en,
  input  logic [PWM_PH_W-1:0] duty,
  output logic                pwm
);

  logic [PWM_PH_W-1:0] phase_q, phase_d;
  logic                pwm_q, pwm_d;

  // phase_q is the phase of the cycle being driven; pwm_q is registered with it.
  always_comb begin
    phase_d = phase_q;
    if (clear) begin
      phase_d = '0;
    end else if (en) begin
      phase_d = phase_q + 1'b1;
    end
    pwm_d = (clear || en) && (phase_d < duty);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q <= '0;
      pwm_q   <= 1'b0;
    end else begin
      phase_q <= phase_d;
      pwm_q   <= pwm_d;
    end
  end

  assign pwm = pwm_q;

endmodule

// File: rtl/irled_ctrl.sv
// IR LED driver sequencer: arbitrates camera/barcode, sequences bias, PWM drive, cool-down and on-time fault.
module irled_ctrl
  import irled_pkg::*;
#(
  parameter int unsigned SETTLE_CYC = 64,
  parameter int unsigned COOL_CYC   = 1024,
  parameter int unsigned MAX_ON_CYC = 65535
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cam_req,
  input  logic [7:0] cam_duty,
  input  logic [7:0] cam_code,
  output logic       cam_ack,
  input  logic       bc_req,
  input  logic [7:0] bc_duty,
  input  logic [7:0] bc_code,
  output logic       bc_ack,
  input  logic       half_cur,
  input  logic       fault_clr,
  output logic       irled_en,
  output logic       barcode_en,
  output logic [7:0] cbit_ir,
  output logic       cbit_ir_half_cur,
  output logic       ir_pwm,
  output logic       busy,
  output logic       fault
);

  localparam logic [SETTLE_CNT_W-1:0] SETTLE_LAST = SETTLE_CNT_W'(SETTLE_CYC - 1);
  localparam logic [COOL_CNT_W-1:0]   COOL_LAST   = COOL_CNT_W'(COOL_CYC - 1);
  localparam logic [ON_CNT_W-1:0]     ON_LAST     = ON_CNT_W'(MAX_ON_CYC - 1);

  state_e                  state_q, state_d;
  owner_t                  owner_q, owner_d;
  owner_t                  last_grant_q, last_grant_d;
  logic [7:0]              duty_q, duty_d;
  logic [7:0]              code_q, code_d;
  logic                    half_q, half_d;
  logic [SETTLE_CNT_W-1:0] settle_q, settle_d;
  logic [COOL_CNT_W-1:0]   cool_q, cool_d;
  logic [ON_CNT_W-1:0]     on_q, on_d;

  logic       irled_en_q, irled_en_d;
  logic       barcode_en_q, barcode_en_d;
  logic [7:0] cbit_ir_q, cbit_ir_d;
  logic       half_cur_q, half_cur_d;
  logic       cam_ack_q, cam_ack_d;
  logic       bc_ack_q, bc_ack_d;
  logic       busy_q, busy_d;
  logic       fault_q, fault_d;

  logic owner_req;
  logic pwm_clear, pwm_en;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    duty_d       = duty_q;
    code_d       = code_q;
    half_d       = half_q;
    settle_d     = '0;
    cool_d       = '0;
    on_d         = '0;
    owner_req    = (owner_q == OWNER_BC) ? bc_req : cam_req;

    unique case (state_q)
      ST_IDLE: begin
        if (cam_req || bc_req) begin
          // A tie goes to whoever did not win the previous grant.
          if (cam_req && bc_req) owner_d = ~last_grant_q;
          else                   owner_d = bc_req ? OWNER_BC : OWNER_CAM;
          last_grant_d = owner_d;
          duty_d       = (owner_d == OWNER_BC) ? bc_duty : cam_duty;
          code_d       = (owner_d == OWNER_BC) ? bc_code : cam_code;
          half_d       = half_cur;
          state_d      = ST_BIAS;
        end
      end
      ST_BIAS: begin
        if (!owner_req)                 state_d = ST_COOL;
        else if (settle_q == SETTLE_LAST) state_d = ST_ON;
        else                            settle_d = settle_q + 1'b1;
      end
      ST_ON: begin
        if (!owner_req)           state_d = ST_COOL;
        else if (on_q == ON_LAST) state_d = ST_FAULT;
        else                      on_d = (&on_q) ? on_q : on_q + 1'b1;
      end
      ST_COOL: begin
        if (cool_q == COOL_LAST) state_d = ST_IDLE;
        else                     cool_d = cool_q + 1'b1;
      end
      ST_FAULT: begin
        if (fault_clr) state_d = ST_COOL;
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are registered from the next state so they line up with the state they describe.
    irled_en_d   = bias_active(state_d);
    barcode_en_d = bias_active(state_d) && (owner_d == OWNER_BC);
    cbit_ir_d    = bias_active(state_d) ? code_d : 8'h00;
    half_cur_d   = bias_active(state_d) && half_d;
    cam_ack_d    = (state_d == ST_ON) && (owner_d == OWNER_CAM);
    bc_ack_d     = (state_d == ST_ON) && (owner_d == OWNER_BC);
    busy_d       = (state_d != ST_IDLE);
    fault_d      = (state_d == ST_FAULT);
    pwm_clear    = (state_d == ST_ON) && (state_q != ST_ON);
    pwm_en       = (state_d == ST_ON) && (state_q == ST_ON);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      owner_q      <= OWNER_CAM;
      last_grant_q <= OWNER_BC;
      duty_q       <= '0;
      code_q       <= '0;
      half_q       <= 1'b0;
      settle_q     <= '0;
      cool_q       <= '0;
      on_q         <= '0;
      irled_en_q   <= 1'b0;
      barcode_en_q <= 1'b0;
      cbit_ir_q    <= 8'h00;
      half_cur_q   <= 1'b0;
      cam_ack_q    <= 1'b0;
      bc_ack_q     <= 1'b0;
      busy_q       <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      duty_q       <= duty_d;
      code_q       <= code_d;
      half_q       <= half_d;
      settle_q     <= settle_d;
      cool_q       <= cool_d;
      on_q         <= on_d;
      irled_en_q   <= irled_en_d;
      barcode_en_q <= barcode_en_d;
      cbit_ir_q    <= cbit_ir_d;
      half_cur_q   <= half_cur_d;
      cam_ack_q    <= cam_ack_d;
      bc_ack_q     <= bc_ack_d;
      busy_q       <= busy_d;
      fault_q      <= fault_d;
    end
  end

  irled_pwm u_pwm (
    .clk   (clk),
    .rst   (rst),
    .clear (pwm_clear),
    .en    (pwm_en),
    .duty  (duty_q),
    .pwm   (ir_pwm)
  );

  assign irled_en         = irled_en_q;
  assign barcode_en       = barcode_en_q;
  assign cbit_ir          = cbit_ir_q;
  assign cbit_ir_half_cur = half_cur_q;
  assign cam_ack          = cam_ack_q;
  assign bc_ack           = bc_ack_q;
  assign busy             = busy_q;
  assign fault            = fault_q;

endmodule

// File: tb/tb_irled_ctrl.sv
// Self-checking bench for irled_ctrl: table-driven grants with a scoreboard, plus abort/fault/reset sequences.
module tb_irled_ctrl;
  import irled_pkg::*;

  localparam int SETTLE   = 4;
  localparam int COOL     = 8;
  localparam int MAX_ON   = 1000;
  localparam int MAX_ON_F = 100;

  logic       clk = 1'b0;
  logic       rst;
  logic       cam_req, bc_req, half_cur, fault_clr;
  logic [7:0] cam_duty, cam_code, bc_duty, bc_code;

  logic       cam_ack, bc_ack, irled_en, barcode_en, cbit_ir_half_cur, ir_pwm, busy, fault;
  logic [7:0] cbit_ir;
  logic       f_cam_ack, f_bc_ack, f_irled_en, f_barcode_en, f_half, f_ir_pwm, f_busy, f_fault;
  logic [7:0] f_cbit_ir;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic       cam;
    logic       bc;
    logic [7:0] cam_duty;
    logic [7:0] cam_code;
    logic [7:0] bc_duty;
    logic [7:0] bc_code;
    logic       half;
    int         on_len;
    logic       exp_bc;
    int         exp_high;
  } vec_t;

  typedef struct {
    logic       bc;
    logic [7:0] code;
    logic [7:0] duty;
    logic       half;
    int         high;
  } exp_t;

  exp_t sb_q[$];
  vec_t vecs[6];

  irled_ctrl #(.SETTLE_CYC(SETTLE), .COOL_CYC(COOL), .MAX_ON_CYC(MAX_ON)) u_dut (
    .clk(clk), .rst(rst),
    .cam_req(cam_req), .cam_duty(cam_duty), .cam_code(cam_code), .cam_ack(cam_ack),
    .bc_req(bc_req), .bc_duty(bc_duty), .bc_code(bc_code), .bc_ack(bc_ack),
    .half_cur(half_cur), .fault_clr(fault_clr),
    .irled_en(irled_en), .barcode_en(barcode_en), .cbit_ir(cbit_ir),
    .cbit_ir_half_cur(cbit_ir_half_cur), .ir_pwm(ir_pwm), .busy(busy), .fault(fault)
  );

  irled_ctrl #(.SETTLE_CYC(SETTLE), .COOL_CYC(COOL), .MAX_ON_CYC(MAX_ON_F)) u_dut_f (
    .clk(clk), .rst(rst),
    .cam_req(cam_req), .cam_duty(cam_duty), .cam_code(cam_code), .cam_ack(f_cam_ack),
    .bc_req(bc_req), .bc_duty(bc_duty), .bc_code(bc_code), .bc_ack(f_bc_ack),
    .half_cur(half_cur), .fault_clr(fault_clr),
    .irled_en(f_irled_en), .barcode_en(f_barcode_en), .cbit_ir(f_cbit_ir),
    .cbit_ir_half_cur(f_half), .ir_pwm(f_ir_pwm), .busy(f_busy), .fault(f_fault)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    exp_t e, got;
    int   lat, highs, pat_err, cool_len;
    check($sformatf("v%0d_idle", idx), busy, 0);
    cam_req  = v.cam;      bc_req   = v.bc;
    cam_duty = v.cam_duty; cam_code = v.cam_code;
    bc_duty  = v.bc_duty;  bc_code  = v.bc_code;
    half_cur = v.half;
    e.bc   = v.exp_bc;
    e.code = v.exp_bc ? v.bc_code : v.cam_code;
    e.duty = v.exp_bc ? v.bc_duty : v.cam_duty;
    e.half = v.half;
    e.high = v.exp_high;
    sb_q.push_back(e);
    tick();
    check($sformatf("v%0d_bias_en", idx), irled_en, 1);
    check($sformatf("v%0d_bias_pwm_ack", idx), {ir_pwm, cam_ack, bc_ack}, 3'b000);
    // Disturb everything after grant: none of it may change the ongoing use.
    half_cur = ~v.half;
    cam_duty = ~v.cam_duty; cam_code = ~v.cam_code;
    bc_duty  = ~v.bc_duty;  bc_code  = ~v.bc_code;
    cam_req  = 1'b1;        bc_req   = 1'b1;
    lat = 1;
    while (!(cam_ack || bc_ack) && lat < 50) begin
      tick();
      lat++;
    end
    check($sformatf("v%0d_ack_latency", idx), lat, SETTLE + 1);
    if (sb_q.size() == 0) begin
      check($sformatf("v%0d_sb_empty", idx), 1, 0);
      return;
    end
    got = sb_q.pop_front();
    check($sformatf("v%0d_acks", idx), {cam_ack, bc_ack}, {~got.bc, got.bc});
    check($sformatf("v%0d_barcode_en", idx), barcode_en, got.bc);
    check($sformatf("v%0d_cbit", idx), cbit_ir, got.code);
    check($sformatf("v%0d_half", idx), cbit_ir_half_cur, got.half);
    highs = 0;
    pat_err = 0;
    for (int k = 0; k < v.on_len; k++) begin
      if (k > 0) tick();
      highs += int'(ir_pwm);
      if (ir_pwm !== ((k % 256) < int'(got.duty))) pat_err++;
      if ((cam_ack | bc_ack) !== 1'b1) pat_err++;
    end
    check($sformatf("v%0d_pwm_high", idx), highs, got.high);
    check($sformatf("v%0d_pwm_pattern", idx), pat_err, 0);
    cam_req = 1'b0;
    bc_req  = 1'b0;
    tick();
    check($sformatf("v%0d_cool_outs", idx),
          {irled_en, barcode_en, cbit_ir, cbit_ir_half_cur, ir_pwm, cam_ack, bc_ack, busy},
          15'h0001);
    cool_len = 0;
    while (busy === 1'b1 && cool_len < 100) begin
      cool_len++;
      tick();
    end
    check($sformatf("v%0d_cool_len", idx), cool_len, COOL);
  endtask

  initial begin
    int   n, on_cnt, bad;
    logic saw_drive;

    rst = 1'b1;
    cam_req = 0; bc_req = 0; half_cur = 0; fault_clr = 0;
    cam_duty = 0; cam_code = 0; bc_duty = 0; bc_code = 0;

    //                cam bc  cdut   ccode  bdut   bcode  half len  bc  high
    vecs[0] = '{1'b1, 1'b1, 8'd64,  8'hA5, 8'd10,  8'h3C, 1'b0, 256, 1'b0, 64};
    vecs[1] = '{1'b1, 1'b1, 8'd20,  8'h11, 8'd32,  8'hC3, 1'b1, 256, 1'b1, 32};
    vecs[2] = '{1'b1, 1'b1, 8'd1,   8'h5A, 8'd99,  8'h77, 1'b0, 256, 1'b0, 1};
    vecs[3] = '{1'b1, 1'b0, 8'd255, 8'hFF, 8'd0,   8'h00, 1'b1, 256, 1'b0, 255};
    vecs[4] = '{1'b0, 1'b1, 8'd200, 8'h01, 8'd0,   8'h5A, 1'b0, 300, 1'b1, 0};
    vecs[5] = '{1'b0, 1'b1, 8'd7,   8'h02, 8'd128, 8'h80, 1'b1, 300, 1'b1, 172};

    tick();
    check("reset_outs",
          {irled_en, barcode_en, cbit_ir, cbit_ir_half_cur, ir_pwm, cam_ack, bc_ack, busy, fault},
          16'h0000);
    tick();
    rst = 1'b0;
    tick();

    for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

    // Request dropped two cycles into BIAS: straight to COOL, never drives.
    cam_req = 1'b1; cam_duty = 8'd200; cam_code = 8'h33;
    tick();
    check("abort_bias_en", irled_en, 1);
    tick();
    cam_req = 1'b0;
    tick();
    saw_drive = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      if (cam_ack || bc_ack || ir_pwm || irled_en) saw_drive = 1'b1;
      n++;
      tick();
    end
    check("abort_no_drive", saw_drive, 0);
    check("abort_cool_len", n, COOL);
    check("abort_idle", {busy, irled_en}, 2'b00);

    // On-time fault on the short-limit instance.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    cam_req = 1'b1; cam_duty = 8'd128; cam_code = 8'h42; half_cur = 1'b0;
    n = 0;
    while (!f_cam_ack && n < 50) begin
      tick();
      n++;
    end
    check("fault_first_ack", f_cam_ack, 1);
    on_cnt = 0;
    while (f_cam_ack === 1'b1 && on_cnt < 500) begin
      on_cnt++;
      tick();
    end
    check("fault_on_len", on_cnt, MAX_ON_F);
    check("fault_outs",
          {f_irled_en, f_barcode_en, f_cbit_ir, f_half, f_ir_pwm, f_cam_ack, f_bc_ack, f_busy, f_fault},
          16'h0003);
    bc_req = 1'b1;
    bad = 0;
    repeat (20) begin
      tick();
      if (f_fault !== 1'b1 || f_irled_en !== 1'b0 || f_cam_ack !== 1'b0 || f_bc_ack !== 1'b0) bad++;
    end
    check("fault_held", bad, 0);
    bc_req = 1'b0;
    fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
    check("fault_clr_cool", {f_fault, f_busy, f_irled_en}, 3'b010);
    n = 0;
    while (!f_irled_en && n < 100) begin
      n++;
      tick();
    end
    check("fault_regrant_gap", n, COOL + 1);
    check("fault_regrant_cam", {f_irled_en, f_barcode_en, f_cbit_ir}, {1'b1, 1'b0, 8'h42});
    n = 0;
    while (!f_cam_ack && n < 50) begin
      tick();
      n++;
    end
    check("fault_regrant_ack", f_cam_ack, 1);

    // Asynchronous reset in the middle of ON, off the clock edge.
    #2;
    rst = 1'b1;
    #1;
    check("midon_reset_f",
          {f_irled_en, f_barcode_en, f_cbit_ir, f_half, f_ir_pwm, f_cam_ack, f_bc_ack, f_busy, f_fault},
          16'h0000);
    check("midon_reset_main",
          {irled_en, barcode_en, cbit_ir, cbit_ir_half_cur, ir_pwm, cam_ack, bc_ack, busy, fault},
          16'h0000);
    cam_req = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    // The last grant before reset was camera; a fresh tie must still go to camera.
    cam_req = 1'b1; bc_req = 1'b1; cam_code = 8'h9C; bc_code = 8'h6D;
    tick();
    check("post_reset_tie", {f_irled_en, f_barcode_en, f_cbit_ir}, {1'b1, 1'b0, 8'h9C});
    n = 1;
    while (!(f_cam_ack || f_bc_ack) && n < 50) begin
      tick();
      n++;
    end
    check("post_reset_latency", n, SETTLE + 1);
    check("post_reset_acks", {f_cam_ack, f_bc_ack}, 2'b10);
    cam_req = 1'b0;
    bc_req  = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/irled_ctrl.md
# irled_ctrl

Sequencer and arbiter for the 400 mA IR LED driver macro. Two requesters share the driver: camera illumination strobe and barcode illumination. The block grants one requester at a time and enables the bias with a settle delay before drive. It programs the 8-bit current code and half-current bit, generates `ir_pwm`, enforces a cool-down between grants, and trips a latched fault on over-long on-time. It sits between the SoC register/strobe logic and the `irled_en`/`barcode_en`/`cbit_ir*`/`ir_pwm` inputs of the IR LED hard block.

## Interface
- `SETTLE_CYC`, default 64: bias settle cycles between enable and drive (≥1).
- `COOL_CYC`, default 1024: mandatory off cycles after every release or fault clear (≥1).
- `MAX_ON_CYC`, default 65535: ON-state cycle limit before fault (≥1, ≤2^20-1).
- `clk` in 1: the single clock.
- `rst` in 1: asynchronous, active-high reset.
- `cam_req` in 1: camera request (level, held for the whole use).
- `cam_duty` in 8: camera PWM duty, in 1/256 steps.
- `cam_code` in 8: camera current code.
- `cam_ack` out 1: camera owns the driver and LED is driving.
- `bc_req`, `bc_duty[7:0]`, `bc_code[7:0]`, `bc_ack`: same as the camera set, for barcode.
- `half_cur` in 1: half-current select, sampled at grant.
- `fault_clr` in 1: single-cycle pulse that clears a fault.
- `irled_en` out 1: driver/bias enable.
- `barcode_en` out 1: barcode-mode enable.
- `cbit_ir` out 8: current code to the macro.
- `cbit_ir_half_cur` out 1: half-current bit to the macro.
- `ir_pwm` out 1: LED PWM drive.
- `busy` out 1: state is not IDLE.
- `fault` out 1: on-time fault latched.

## Operation
- States: IDLE, BIAS, ON, COOL, FAULT.
- **IDLE.**
  - If one request is high, grant it.
  - If both are high, grant the requester that did not win the last grant. `last_grant` resets to barcode, so the camera wins the first tie.
  - At grant, latch owner, duty, code and `half_cur`. Go to BIAS.
- **BIAS.**
  - `irled_en`=1, `cbit_ir`/`cbit_ir_half_cur` = latched values, `barcode_en`=1 if the owner is barcode, `ir_pwm`=0, ack=0.
  - After `SETTLE_CYC` cycles, go to ON.
  - If the owner's request drops, go to COOL without passing through ON.
- **ON.**
  - BIAS outputs stay as they were. The owner's ack is 1.
  - `ir_pwm` = (k mod 256) < duty, where k = ON cycle index starting at 0. Duty 0 gives a constant 0; duty 255 gives high 255 of every 256 cycles.
  - Owner request low: go to COOL.
  - k reaches `MAX_ON_CYC`: go to FAULT.
- **COOL.**
  - All LED outputs and acks are 0.
  - After `COOL_CYC` cycles, go to IDLE.
  - Requests seen during COOL are ignored until IDLE.
- **FAULT.**
  - All LED outputs 0, `fault`=1.
  - `fault_clr` goes to COOL and clears `fault`.
  - Requests are ignored while in FAULT.
- Changes to the non-owner's request, or to duty/code inputs, after grant have no effect.
- Reset, asynchronous at any time including mid-ON: state IDLE and every output 0 (`irled_en`, `barcode_en`, `cbit_ir`=8'h00, `cbit_ir_half_cur`, `ir_pwm`, both acks, `busy`, `fault`). All counters are 0 and `last_grant`=barcode.

## Timing
- All outputs are registered and reflect the current state.
- Request seen high in IDLE at edge n: BIAS at n+1, `irled_en` high from n+1.
- First ON cycle is n+1+`SETTLE_CYC`. Ack and the first `ir_pwm` high (duty>0) occur in that cycle.
- Request drop seen at edge m in ON: COOL at m+1. Ack, `ir_pwm` and `irled_en` are low from m+1.
- The next grant is sampled at m+1+`COOL_CYC` at the earliest.
- Fault: the ON state lasts exactly `MAX_ON_CYC` cycles, then FAULT.
- `fault_clr` in FAULT at edge f: COOL at f+1.
- ON counter is 20 bits and saturates, with no wrap. The PWM phase is its low 8 bits. Settle and cool counters are 16 bits.

## Structure
- `irled_pkg` holds:
  - the state enum;
  - the `OWNER_CAM`/`OWNER_BC` constants;
  - the counter width localparams.
- Sub-module `irled_pwm`: 8-bit phase counter plus compare. It is cleared on ON entry and enabled only in ON.
- The FSM, arbitration and latches stay in `irled_ctrl`.

## Test plan
- Single camera request, duty 8'd64, code 8'hA5, `SETTLE_CYC`=4 → `irled_en` 1 cycle after grant; `cam_ack` 5 cycles after grant; `ir_pwm` high for 64 of every 256 cycles; `cbit_ir`=8'hA5; `barcode_en`=0.
- Both requests high together from reset → camera granted first. After camera release and `COOL_CYC`, barcode is granted with `barcode_en`=1. A subsequent tie goes to camera again.
- Request dropped 2 cycles into BIAS → no ack, `ir_pwm` never high, COOL lasts `COOL_CYC` cycles, `busy` low afterwards.
- `MAX_ON_CYC`=100, request held → `fault`=1 and outputs 0 after 100 ON cycles. Requests are ignored until `fault_clr`, then the cool period runs, then the held request is re-granted.
- Boundary duties: 8'd0 gives constant 0 and 8'd255 gives exactly one low cycle per 256. `half_cur` changes after grant do not alter `cbit_ir_half_cur`.
- `rst` asserted mid-ON at a non-edge time → all outputs 0 immediately. After deassert, a request behaves like the first request after reset.
